// File: rtl/uart_rx_if.sv
// Bundle of the receiver's serial input, output word handshake and status flags.
// The receiver core uses the slave view; a consumer or test driver uses the master view.
interface uart_rx_if #(
  parameter int DataLength = 8
);
  logic                  i_rx;
  logic [DataLength-1:0] o_rx_data;
  logic                  o_rx_valid;
  logic                  i_rx_ready;
  logic                  o_rx_error;
  logic                  o_rx_overrun;
  logic                  i_err_clr;
  logic                  o_busy;

  modport slave (
    input  i_rx, i_rx_ready, i_err_clr,
    output o_rx_data, o_rx_valid, o_rx_error, o_rx_overrun, o_busy
  );

  modport master (
    output i_rx, i_rx_ready, i_err_clr,
    input  o_rx_data, o_rx_valid, o_rx_error, o_rx_overrun, o_busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with a valid/ready word output and sticky framing/overrun flags.
// Define UART_RX_MAJORITY_EN to vote 2-of-3 over the ticks around each mid-bit point.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level
// START     | checking the start bit at its middle
// DATA      | shifting in data bits, LSB first
// STOP      | checking the stop bit, delivering the word
// WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx_core #(
  parameter int DataLength      = 8,
  parameter int OverSample      = 8,
  parameter int BaudRate        = 115200,
  parameter int SystemClockFreq = 133_000_000
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  uart_rx_if.slave bus
);
  localparam int Div   = SystemClockFreq / (BaudRate * OverSample);
  localparam int DivW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int TickW = $clog2(OverSample + 2);
  localparam int BitW  = $clog2(DataLength + 1);
  localparam logic [TickW-1:0] StartMid = TickW'(OverSample / 2 - 1);
  localparam logic [TickW-1:0] BitMid   = TickW'(OverSample - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t                state;
  logic                  rx_meta, rx_sync;
  logic [DivW-1:0]       div_cnt;
  logic [TickW-1:0]      tick_cnt;
  logic [BitW-1:0]       bit_cnt;
  logic [DataLength-1:0] shift;
  logic [DataLength-1:0] rx_data;
  logic                  rx_valid, rx_error, rx_overrun, busy;
  logic                  tick, decide, sample;
  logic [TickW-1:0]      mid, restart;
`ifdef UART_RX_MAJORITY_EN
  logic                  s_early, s_mid;
`endif

  always_comb begin
    tick = (div_cnt == DivW'(Div - 1));
    mid  = (state == START) ? StartMid : BitMid;
`ifdef UART_RX_MAJORITY_EN
    // Decision is taken one tick after mid, so the next bit's count starts at 1.
    decide  = tick && (tick_cnt == mid + TickW'(1));
    sample  = (s_early & s_mid) | (s_early & rx_sync) | (s_mid & rx_sync);
    restart = TickW'(1);
`else
    decide  = tick && (tick_cnt == mid);
    sample  = rx_sync;
    restart = '0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= IDLE;
      busy       <= 1'b0;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_error   <= 1'b0;
      rx_overrun <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      s_early    <= 1'b1;
      s_mid      <= 1'b1;
`endif
    end else begin
      rx_meta <= bus.i_rx;
      rx_sync <= rx_meta;
      div_cnt <= tick ? '0 : div_cnt + DivW'(1);
      if (tick) tick_cnt <= tick_cnt + TickW'(1);
      if (rx_valid && bus.i_rx_ready) rx_valid <= 1'b0;
      // Clear first so a flag set later in this block wins.
      if (bus.i_err_clr) begin
        rx_error   <= 1'b0;
        rx_overrun <= 1'b0;
      end
`ifdef UART_RX_MAJORITY_EN
      if (tick && tick_cnt == mid - TickW'(1)) s_early <= rx_sync;
      if (tick && tick_cnt == mid) s_mid <= rx_sync;
`endif
      case (state)
        IDLE: if (!rx_sync) begin
          state    <= START;
          busy     <= 1'b1;
          div_cnt  <= '0;
          tick_cnt <= '0;
        end
        START: if (decide) begin
          if (sample) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= DATA;
            tick_cnt <= restart;
            bit_cnt  <= '0;
          end
        end
        DATA: if (decide) begin
          shift    <= {sample, shift[DataLength-1:1]};
          tick_cnt <= restart;
          if (bit_cnt == BitW'(DataLength - 1)) state <= STOP;
          else bit_cnt <= bit_cnt + BitW'(1);
        end
        STOP: if (decide) begin
          if (sample) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (rx_valid) rx_overrun <= 1'b1;
            else begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end
          end else begin
            rx_error <= 1'b1;
            state    <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: if (rx_sync) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_rx_data    = rx_data;
  assign bus.o_rx_valid   = rx_valid;
  assign bus.o_rx_error   = rx_error;
  assign bus.o_rx_overrun = rx_overrun;
  assign bus.o_busy       = busy;
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed/random bench for uart_rx_core: frames are built bit by bit at the nominal bit period
// and received words are compared against the words that were sent.
module tb_uart_rx_core;
  localparam int DL     = 8;
  localparam int OS     = 8;
  localparam int Baud   = 115200;
  localparam int SysClk = 12_000_000;
  localparam int Div    = SysClk / (Baud * OS);
  localparam int BitT   = Div * OS;
  localparam int FrameT = (DL + 2) * BitT;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [DL-1:0] exp_q[$];
  logic [DL-1:0] got_q[$];

  uart_rx_if #(.DataLength(DL)) bus ();

  uart_rx_core #(
    .DataLength(DL),
    .OverSample(OS),
    .BaudRate(Baud),
    .SystemClockFreq(SysClk)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n === 1'b1 && bus.o_rx_valid === 1'b1 && bus.i_rx_ready === 1'b1)
      got_q.push_back(bus.o_rx_data);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line level for cycle c: start bit, data LSB first, stop bit; [glo,ghi] forced high.
  task automatic send_frame(input logic [DL-1:0] data, input logic stop_bit,
                            input int glo, input int ghi, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      int   b;
      logic v;
      b = c / BitT;
      if (b == 0) v = 1'b0;
      else if (b <= DL) v = data[b-1];
      else v = stop_bit;
      if (c >= glo && c <= ghi) v = 1'b1;
      bus.i_rx = v;
      cycles(1);
    end
    bus.i_rx = 1'b1;
  endtask

  task automatic consume(input string tag);
    bus.i_rx_ready = 1'b1;
    cycles(1);
    bus.i_rx_ready = 1'b0;
    check(tag, bus.o_rx_valid, 1'b0);
  endtask

  initial begin
    logic [DL-1:0] w;
    int n;
    int glo;
    bus.i_rx       = 1'b1;
    bus.i_rx_ready = 1'b0;
    bus.i_err_clr  = 1'b0;
    rst_n          = 1'b0;
    cycles(4);
    check("rst_data", bus.o_rx_data, 0);
    check("rst_valid", bus.o_rx_valid, 0);
    check("rst_error", bus.o_rx_error, 0);
    check("rst_overrun", bus.o_rx_overrun, 0);
    check("rst_busy", bus.o_busy, 0);
    rst_n = 1'b1;
    cycles(10);

    send_frame(8'hA5, 1'b1, -1, -1, FrameT);
    cycles(4);
    check("a5_valid", bus.o_rx_valid, 1);
    check("a5_data", bus.o_rx_data, 8'hA5);
    check("a5_error", bus.o_rx_error, 0);
    check("a5_overrun", bus.o_rx_overrun, 0);
    check("a5_busy", bus.o_busy, 0);
    consume("a5_taken");

    got_q.delete();
    exp_q.delete();
    bus.i_rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = DL'($urandom_range(0, 255));
      exp_q.push_back(w);
      send_frame(w, 1'b1, -1, -1, FrameT);
    end
    cycles(4);
    bus.i_rx_ready = 1'b0;
    check("burst_count", 16'(got_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      w = (i < got_q.size()) ? got_q[i] : ~exp_q[i];
      check("burst_word", w, exp_q[i]);
    end
    check("burst_overrun", bus.o_rx_overrun, 0);

    bus.i_rx = 1'b0;
    cycles(20);
    bus.i_rx = 1'b1;
    cycles(10 * BitT);
    check("glitch_valid", bus.o_rx_valid, 0);
    check("glitch_busy", bus.o_busy, 0);
    check("glitch_error", bus.o_rx_error, 0);
    check("glitch_overrun", bus.o_rx_overrun, 0);
    send_frame(8'h3C, 1'b1, -1, -1, FrameT);
    cycles(4);
    check("after_glitch_valid", bus.o_rx_valid, 1);
    check("after_glitch_data", bus.o_rx_data, 8'h3C);
    consume("after_glitch_taken");

    send_frame(8'h96, 1'b0, -1, -1, FrameT);
    n = 0;
    while (bus.o_rx_error !== 1'b1 && n < 10) begin
      cycles(1);
      n++;
    end
    check("ferr_flag", bus.o_rx_error, 1);
    n = 0;
    while (bus.o_busy !== 1'b0 && n < 10) begin
      cycles(1);
      n++;
    end
    check("ferr_idle", bus.o_busy, 0);
    check("ferr_valid", bus.o_rx_valid, 0);
    rst_n = 1'b0;
    cycles(2);
    check("ferr_rst_clear", bus.o_rx_error, 0);
    rst_n = 1'b1;
    cycles(5);
    send_frame(8'h5A, 1'b1, -1, -1, FrameT);
    cycles(4);
    check("ferr_next_valid", bus.o_rx_valid, 1);
    check("ferr_next_data", bus.o_rx_data, 8'h5A);
    check("ferr_next_error", bus.o_rx_error, 0);
    consume("ferr_next_taken");

    send_frame(8'h11, 1'b1, -1, -1, FrameT);
    send_frame(8'h22, 1'b1, -1, -1, FrameT);
    cycles(4);
    check("ovr_data", bus.o_rx_data, 8'h11);
    check("ovr_valid", bus.o_rx_valid, 1);
    check("ovr_flag", bus.o_rx_overrun, 1);
    check("ovr_error", bus.o_rx_error, 0);
    bus.i_err_clr = 1'b1;
    cycles(1);
    bus.i_err_clr = 1'b0;
    check("ovr_clr", bus.o_rx_overrun, 0);
    check("ovr_keep_data", bus.o_rx_data, 8'h11);
    consume("ovr_taken");

    // One tick of high level centred on the middle of data bit 3.
    glo = 4 * BitT + BitT / 2 - Div / 2;
    send_frame(8'h00, 1'b1, glo, glo + Div - 1, FrameT);
`ifdef UART_RX_MAJORITY_EN
    w = 8'h00;
`else
    w = 8'h08;
`endif
    cycles(4);
    check("mid_glitch_valid", bus.o_rx_valid, 1);
    check("mid_glitch_data", bus.o_rx_data, w);
    consume("mid_glitch_taken");

    send_frame(8'h00, 1'b1, -1, -1, 3 * BitT + 10);
    check("midrst_busy_pre", bus.o_busy, 1);
    rst_n = 1'b0;
    cycles(2);
    check("midrst_busy", bus.o_busy, 0);
    check("midrst_valid", bus.o_rx_valid, 0);
    rst_n = 1'b1;
    cycles(5);
    w = DL'($urandom_range(0, 255));
    send_frame(w, 1'b1, -1, -1, FrameT);
    cycles(4);
    check("midrst_next_valid", bus.o_rx_valid, 1);
    check("midrst_next_data", bus.o_rx_data, w);
    consume("midrst_next_taken");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 The module SHALL have parameter DataLength, default 8, meaning data bits per frame (5..9).
REQ-002 The module SHALL have parameter OverSample, default 8, meaning sample ticks per bit (even, >=4).
REQ-003 The module SHALL have parameter BaudRate, default 115200, meaning line bit rate in Hz.
REQ-004 The module SHALL have parameter SystemClockFreq, default 133_000_000, meaning i_clk frequency in Hz.
REQ-005 The module SHALL have port i_clk  in  1  system clock; the design uses one clock, all logic on rising edge.
REQ-006 The module SHALL have port i_rst_n  in  1  reset; reset is synchronous and active-low.
REQ-007 The module SHALL have port i_rx  in  1  asynchronous serial line, idle high.
REQ-008 The module SHALL have port o_rx_data  out  DataLength  received word.
REQ-009 The module SHALL have port o_rx_valid  out  1  o_rx_data holds an unconsumed word.
REQ-010 The module SHALL have port i_rx_ready  in  1  consumer accepts the word.
REQ-011 The module SHALL have port o_rx_error  out  1  sticky framing error (stop bit sampled 0).
REQ-012 The module SHALL have port o_rx_overrun  out  1  sticky overrun, meaning a frame completed while o_rx_valid was high.
REQ-013 The module SHALL have port i_err_clr  in  1  single-cycle clear of both sticky flags.
REQ-014 The module SHALL have port o_busy  out  1  high in any state other than IDLE.

Function
REQ-015 i_rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value, which adds 2 cycles of latency.
REQ-016 Tick divider DIV = SystemClockFreq/(BaudRate*OverSample) SHALL use integer truncation (144 at defaults); a one-cycle tick SHALL fire when the counter reaches DIV-1, after which the counter wraps to 0.
REQ-017 The divider and tick count SHALL be zeroed on the cycle the IDLE->START transition occurs, so that bits are phase-aligned to the start edge.
REQ-018 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-019 IDLE->START SHALL occur on synchronized rx == 0.
REQ-020 START SHALL sample at tick OverSample/2-1; a sampled 1 SHALL return the FSM to IDLE with no output (glitch rejection), and a sampled 0 SHALL clear the tick count and go to DATA.
REQ-021 DATA SHALL sample every OverSample ticks and shift the bits in LSB first; after DataLength bits the FSM SHALL go to STOP.
REQ-022 STOP SHALL sample after OverSample ticks, at mid-stop-bit. On a sampled 1, with o_rx_valid low, the block SHALL load o_rx_data and set o_rx_valid on the next edge, then go to IDLE. On a sampled 1 with o_rx_valid high, it SHALL discard the new word, set o_rx_overrun, keep the old word, and go to IDLE.
REQ-023 A STOP sample of 0 SHALL set o_rx_error, discard the word, and go to WAIT_HIGH; WAIT_HIGH SHALL go to IDLE once synchronized rx == 1, so that a break is not retriggered.
REQ-024 Handshake: a transfer SHALL occur on a cycle where o_rx_valid && i_rx_ready, and o_rx_valid SHALL clear on the next edge. o_rx_data SHALL be stable while o_rx_valid is high.
REQ-025 Load and transfer on the same cycle SHALL NOT be possible, because the load only occurs when valid is low, as REQ-022 states.
REQ-026 If a flag set and i_err_clr occur on the same cycle, the set SHALL win.
REQ-027 End-of-frame to o_rx_valid latency SHALL be at most 1 cycle after the mid-stop sample.

Reset
REQ-028 While i_rst_n is low at a clock edge, the block SHALL go to IDLE and zero the divider, tick, bit and shift registers; the synchronizer flops SHALL be set to 1.
REQ-029 The reset values SHALL be o_rx_data=0, o_rx_valid=0, o_rx_error=0, o_rx_overrun=0 and o_busy=0.
REQ-030 A reset asserted mid-frame SHALL abandon the frame. After reset release, the next falling edge starts a new frame.

Configuration
REQ-031 The macro UART_RX_MAJORITY_EN SHALL control mid-bit sampling.
REQ-032 When UART_RX_MAJORITY_EN is defined, each START/DATA/STOP sample SHALL be the 2-of-3 majority of the ticks at mid-1, mid and mid+1.
REQ-033 When UART_RX_MAJORITY_EN is not defined, the single sample at the mid tick SHALL be used.

Verification
REQ-034 Frame 0xA5 at 115200 baud, defaults, i_rx_ready low -> o_rx_data=0xA5 and o_rx_valid=1, with no flags set.
REQ-035 Eight back-to-back random frames with i_rx_ready held high -> eight valid pulses, with data in order and matching the frames.
REQ-036 i_rx low for 20 cycles then high for 10 bit periods -> o_rx_valid=0, o_busy=0, no flags; a following frame 0x3C -> 0x3C.
REQ-037 Frame with stop bit 0 then line high -> o_rx_error=1 within 10 cycles and no valid. Reset clears o_rx_error, and a following frame 0x5A -> 0x5A.
REQ-038 Two frames 0x11 then 0x22 with i_rx_ready low -> o_rx_data=0x11 and o_rx_overrun=1; i_err_clr -> o_rx_overrun=0.
REQ-039 With UART_RX_MAJORITY_EN defined, frame 0x00 with a 1-tick high glitch at mid bit 3 -> 0x00; without the macro and the glitch on the mid tick -> 0x08.
